// File: rtl/adc_resp_pkg.sv
// Shared types and constants for the ADC SPI responder: FSM states, MOSI command
// codes and the position of the underrun flag in the transmitted frame.
package adc_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } resp_state_e;

    // Top two bits of a completed MOSI word select a test-pattern command.
    localparam logic [1:0] CMD_PAT_SET = 2'b10;
    localparam logic [1:0] CMD_PAT_CLR = 2'b11;

    // The underrun flag is always the frame MSB, whatever the frame length.
    function automatic int underrun_bit(input int frame_bits);
        return frame_bits - 1;
    endfunction

endpackage

// File: rtl/adc_resp_fifo.sv
// Small synchronous FIFO with show-ahead head output; push while full and pop while
// empty are ignored internally so callers may drive them unguarded.
module adc_resp_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/adc_spi_responder.sv
// SPI-slave ADC emulator: oversamples the SPI pins in clk, sends one FIFO sample per
// chip-select frame on MISO and captures the MOSI word. Option: ADC_RESP_TEST_PATTERN_EN.
module adc_spi_responder #(
    parameter int DATA_W     = 14,
    parameter int FRAME_BITS = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          adc_cs_n,
    input  logic                          adc_sclk,
    input  logic                          adc_mosi,
    output logic                          adc_miso,
    input  logic [DATA_W-1:0]             sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic [FRAME_BITS-1:0]         rx_data,
    output logic                          rx_valid,
    output logic                          frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    import adc_resp_pkg::*;

    localparam int CNT_W  = $clog2(FRAME_BITS + 1);
    localparam int UR_BIT = underrun_bit(FRAME_BITS);

    // Chip select chain resets to "selected" so a CS already low when reset releases
    // is never mistaken for a fresh falling edge.
    logic [2:0] cs_q;
    logic [2:0] sclk_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_q   <= '0;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            cs_q   <= {cs_q[1:0], adc_cs_n};
            sclk_q <= {sclk_q[1:0], adc_sclk};
            mosi_q <= {mosi_q[0], adc_mosi};
        end
    end

    logic cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;
    assign cs_fall   =  cs_q[2] & ~cs_q[1];
    assign cs_rise   = ~cs_q[2] &  cs_q[1];
    assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
    assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
    assign mosi_s    =  mosi_q[1];

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    adc_resp_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (sample_valid),
        .din   (sample_in),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    resp_state_e           state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-2:0] rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  miso_q, miso_d;
    logic [DATA_W-1:0]     last_q, last_d;
    logic                  overflow_q;
    logic [FRAME_BITS-1:0] word_done;

`ifdef ADC_RESP_TEST_PATTERN_EN
    logic [7:0] pattern_q, pattern_d;
    logic       pattern_mode_q, pattern_mode_d;
`endif

    // Sample sits just below the two flag bits; any spare low bits stay zero.
    function automatic logic [FRAME_BITS-1:0] build_word(input logic [DATA_W-1:0] s,
                                                         input logic ur);
        logic [FRAME_BITS-1:0] w;
        w                         = '0;
        w[UR_BIT]                 = ur;
        w[FRAME_BITS-3 -: DATA_W] = s;
        return w;
    endfunction

    assign word_done = {rx_shift_q, mosi_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso_q;
        last_d      = last_q;
        fifo_pop    = 1'b0;
`ifdef ADC_RESP_TEST_PATTERN_EN
        pattern_d      = pattern_q;
        pattern_mode_d = pattern_mode_q;
`endif
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
`ifdef ADC_RESP_TEST_PATTERN_EN
                if (pattern_mode_q) begin
                    tx_d      = '0;
                    tx_d[7:0] = pattern_q;
                end else
`endif
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    tx_d     = build_word(fifo_head, 1'b0);
                    last_d   = fifo_head;
                end else begin
                    tx_d = build_word(last_q, 1'b1);
                end
                miso_d    = tx_d[FRAME_BITS-1];
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_d = word_done[FRAME_BITS-2:0];
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    // The last rising edge completes the word; publish it right away.
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        rx_data_d  = word_done;
                        rx_valid_d = 1'b1;
                        miso_d     = 1'b0;
                        state_d    = DONE;
`ifdef ADC_RESP_TEST_PATTERN_EN
                        if (word_done[FRAME_BITS-1 -: 2] == CMD_PAT_SET) begin
                            pattern_d      = word_done[7:0];
                            pattern_mode_d = 1'b1;
                        end else if (word_done[FRAME_BITS-1 -: 2] == CMD_PAT_CLR) begin
                            pattern_mode_d = 1'b0;
                        end
`endif
                    end
                end else if (sclk_fall && (bit_cnt_q < CNT_W'(FRAME_BITS))) begin
                    tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
                    miso_d = tx_d[FRAME_BITS-1];
                end
            end
            DONE: begin
                miso_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cs_rise) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            if ((state_q == SHIFT) && !rx_valid_d) begin
                frame_err_d = 1'b1;
                rx_shift_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            last_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            last_q      <= last_d;
            overflow_q  <= overflow_q | (sample_valid & fifo_full);
        end
    end

`ifdef ADC_RESP_TEST_PATTERN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q      <= '0;
            pattern_mode_q <= 1'b0;
        end else begin
            pattern_q      <= pattern_d;
            pattern_mode_q <= pattern_mode_d;
        end
    end
`endif

    // MISO is forced low by the raw pin so it is quiet the moment CS deasserts.
    assign adc_miso     = miso_q & ~adc_cs_n;
    assign sample_ready = ~fifo_full;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign frame_err    = frame_err_q;
    assign overflow     = overflow_q;

endmodule
